// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and one-entry IR front end feeding decode with valid/ready, jumps and HALT.
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic load;
    assign rom_addr = pc;
    assign halted = state == HALTED;
    assign load = state == RUN && !jump_en && (!ir_valid || ir_ready);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = load && rom_data == HALT_OPCODE ? HALTED : RUN;
            HALTED:  state_nxt = jump_en ? RUN : HALTED;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (jump_en) begin
                pc       <= jump_addr;
                ir_valid <= 1'b0;
            end else if (load) begin
                ir       <= rom_data;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
                pc       <= pc + 1'b1;
            end else if (ir_valid && ir_ready) begin
                ir_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, backpressure, jump flush, HALT, PC wrap and async reset.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n, start, jump_en, ir_ready, ir_valid, halted;
    logic [7:0] rom_addr, rom_data, jump_addr, ir, ir_pc;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    assign rom_data = rom_addr == 8'h10 ? 8'hFF : rom_addr ^ 8'h5A;
    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .jump_en(jump_en), .jump_addr(jump_addr), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .halted(halted)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    initial begin
        rst_n = 1'b0; start = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; ir_ready = 1'b1;
        #1;
        check("rst_valid", ir_valid, 0);
        check("rst_addr", rom_addr, 8'h00);
        check("rst_halted", halted, 0);
        check("rst_ir", ir, 0);
        check("rst_ir_pc", ir_pc, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_fetch", ir_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_first_valid", ir_valid, 0);
        check("run_first_addr", rom_addr, 8'h00);
        tick();
        check("seq0_ir", ir, 8'h5A);
        check("seq0_pc", ir_pc, 8'h00);
        check("seq0_valid", ir_valid, 1);
        tick();
        check("seq1_ir", ir, 8'h5B);
        check("seq1_pc", ir_pc, 8'h01);
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ir", ir, 8'h5B);
            check("bp_pc", ir_pc, 8'h01);
            check("bp_addr", rom_addr, 8'h02);
            check("bp_valid", ir_valid, 1);
        end
        ir_ready = 1'b1;
        tick();
        check("bp_rel_ir", ir, 8'h58);
        check("bp_rel_pc", ir_pc, 8'h02);
        jump_en = 1'b1; jump_addr = 8'h0A;
        tick();
        jump_en = 1'b0;
        check("jmp_flush", ir_valid, 0);
        check("jmp_addr", rom_addr, 8'h0A);
        tick();
        check("jmp_ir", ir, 8'h50);
        check("jmp_pc", ir_pc, 8'h0A);
        check("jmp_valid", ir_valid, 1);
        repeat (6) tick();
        check("halt_ir", ir, 8'hFF);
        check("halt_pc", ir_pc, 8'h10);
        check("halt_valid", ir_valid, 1);
        check("halt_flag", halted, 1);
        check("halt_pc_inc", rom_addr, 8'h11);
        tick();
        check("halt_consumed", ir_valid, 0);
        check("halt_addr_hold", rom_addr, 8'h11);
        tick();
        check("halt_no_load", ir_valid, 0);
        check("halt_still", halted, 1);
        jump_en = 1'b1; jump_addr = 8'h00;
        tick();
        jump_en = 1'b0;
        check("resume_halted", halted, 0);
        check("resume_addr", rom_addr, 8'h00);
        tick();
        check("resume_ir", ir, 8'h5A);
        check("resume_pc", ir_pc, 8'h00);
        jump_en = 1'b1; jump_addr = 8'hFE;
        tick();
        jump_en = 1'b0;
        tick();
        check("wrap0_pc", ir_pc, 8'hFE);
        check("wrap0_ir", ir, 8'hA4);
        tick();
        check("wrap1_pc", ir_pc, 8'hFF);
        check("wrap1_ir", ir, 8'hA5);
        tick();
        check("wrap2_pc", ir_pc, 8'h00);
        check("wrap2_ir", ir, 8'h5A);
        check("wrap2_valid", ir_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", ir_valid, 0);
        check("arst_addr", rom_addr, 8'h00);
        check("arst_halted", halted, 0);
        check("arst_ir", ir, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("arst_idle_valid", ir_valid, 0);
        check("arst_idle_addr", rom_addr, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_ir", ir, 8'h5A);
        check("restart_valid", ir_valid, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
